// File: rtl/common.sv
// Shared types and defaults for the instruction prefetch queue.
package common;

    localparam int PREFETCH_DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } prefetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO of prefetch entries; flush clears it in one cycle.
module prefetch_fifo
    import common::*;
#(
    parameter  int DEPTH = PREFETCH_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic            i_flush,
    input  prefetch_entry_t i_wdata,
    output prefetch_entry_t o_rdata,
    output logic [CW-1:0]   o_count,
    output logic            o_full,
    output logic            o_empty
);

    prefetch_entry_t r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

    always_ff @(posedge clk) begin
        if (i_push && !i_flush && !rst) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !i_flush) begin
            assert (!(i_push && !i_pop && o_full));
            assert (!(i_pop && o_empty));
        end
    end

endmodule

// File: rtl/instruction_prefetch.sv
// Prefetch queue between instruction memory and fetch, with branch redirect.
// Optional PREFETCH_BYPASS_EN forwards a response straight to the output when the queue is empty.
module instruction_prefetch
    import common::*;
#(
    parameter int                    DEPTH      = PREFETCH_DEPTH,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_instr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] S_RESET    = 2'd0;
    localparam logic [1:0] S_RUN      = 2'd1;
    localparam logic [1:0] S_REDIRECT = 2'd2;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] r_rsp_pc;
    logic                  r_inflight;

    logic                  w_redirect;
    logic                  w_credit_ok;
    logic                  w_issue;
    logic                  w_rsp_vld;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_valid;
    logic [CW-1:0]         w_count;
    logic                  w_full;
    logic                  w_empty;
    prefetch_entry_t       w_head;
    prefetch_entry_t       w_rsp;
    prefetch_entry_t       w_sel;
    logic                  w_unused;

    assign w_unused = &{1'b0, branch_target[1:0], w_full};

    assign w_redirect  = branch_taken && (r_state != S_RESET);
    assign w_credit_ok = (w_count + CW'(r_inflight)) < CW'(DEPTH);

    // A response returning in a redirect cycle belongs to the old stream and is dropped.
    assign w_rsp_vld = r_inflight && !w_redirect;
    assign w_rsp     = '{pc: r_rsp_pc, instr: mem_rd_data};

`ifdef PREFETCH_BYPASS_EN
    assign w_valid = !rst && !branch_taken && (!w_empty || w_rsp_vld);
    assign w_sel   = w_empty ? w_rsp : w_head;
    assign w_push  = w_rsp_vld && !(w_empty && w_pop);
`else
    assign w_valid = !rst && !branch_taken && !w_empty;
    assign w_sel   = w_head;
    assign w_push  = w_rsp_vld;
`endif

    assign w_pop = w_valid && out_ready;

    always_comb begin
        w_issue = 1'b0;
        if (!rst && !w_redirect) begin
            case (r_state)
                S_RUN:      w_issue = w_credit_ok || w_pop;
                S_REDIRECT: w_issue = 1'b1;
                default:    w_issue = 1'b0;
            endcase
        end
    end

    assign mem_rd_en   = w_issue;
    assign mem_rd_addr = r_fetch_pc;
    assign out_valid   = w_valid;
    assign out_pc      = w_valid ? w_sel.pc : '0;
    assign out_instr   = w_valid ? w_sel.instr : '0;

    prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_redirect),
        .i_wdata (w_rsp),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_RESET;
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) r_rsp_pc <= r_fetch_pc;
            if (w_redirect) begin
                r_fetch_pc <= {branch_target[ADDR_WIDTH-1:2], 2'b00};
                r_state    <= S_REDIRECT;
            end else begin
                if (w_issue) r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(4);
                r_state <= S_RUN;
            end
        end
    end

endmodule

// File: tb/tb_instruction_prefetch.sv
// Directed bench for instruction_prefetch (default build, queue-only output path).
module tb_instruction_prefetch;

    localparam logic [31:0] K = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_rd_en;
    logic [31:0] mem_rd_addr;
    logic [31:0] mem_rd_data = 32'h0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        r;
        logic        rdy;
        logic        br;
        logic [31:0] tgt;
        logic        een;
        logic [31:0] eaddr;
        logic        evld;
        logic [31:0] epc;
    } vec_t;

    vec_t tbl[$];

    instruction_prefetch dut (
        .clk           (clk),
        .rst           (rst),
        .mem_rd_en     (mem_rd_en),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_data   (mem_rd_data),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_instr     (out_instr)
    );

    always #5 clk = ~clk;

    // Memory returns a tagged copy of the address one cycle after a read; junk otherwise.
    always @(posedge clk) mem_rd_data <= mem_rd_en ? (mem_rd_addr ^ K) : 32'hBAD0_BAD0;

    function automatic vec_t mk(input logic r, input logic rdy, input logic br, input logic [31:0] tgt,
                                input logic een, input logic [31:0] ea, input logic evld, input logic [31:0] ep);
        vec_t v;
        v.r = r; v.rdy = rdy; v.br = br; v.tgt = tgt;
        v.een = een; v.eaddr = ea; v.evld = evld; v.epc = ep;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after a falling edge, check, then advance one full cycle.
    task automatic cyc(input string nm, input vec_t v);
        rst = v.r; out_ready = v.rdy; branch_taken = v.br; branch_target = v.tgt;
        #2;
        chk({nm, ".rd_en"}, {31'b0, mem_rd_en}, {31'b0, v.een});
        if (v.een) chk({nm, ".rd_addr"}, mem_rd_addr, v.eaddr);
        chk({nm, ".valid"}, {31'b0, out_valid}, {31'b0, v.evld});
        if (v.evld) begin
            chk({nm, ".pc"}, out_pc, v.epc);
            chk({nm, ".instr"}, out_instr, v.epc ^ K);
        end else begin
            chk({nm, ".pc0"}, out_pc, 32'h0);
        end
        @(negedge clk);
    endtask

    task automatic run(input string nm, input logic r, input logic rdy, input logic br, input logic [31:0] tgt,
                       input logic een, input logic [31:0] ea, input logic evld, input logic [31:0] ep);
        cyc(nm, mk(r, rdy, br, tgt, een, ea, evld, ep));
    endtask

    initial begin
        // Streaming from reset, then a stall/drain; then a fresh reset with a long stall.
        tbl.push_back(mk(1,1,0,0, 0,32'h00, 0,0));
        tbl.push_back(mk(1,1,0,0, 0,32'h00, 0,0));
        tbl.push_back(mk(0,1,0,0, 0,32'h00, 0,0));
        tbl.push_back(mk(0,1,0,0, 1,32'h00, 0,0));
        tbl.push_back(mk(0,1,0,0, 1,32'h04, 0,0));
        tbl.push_back(mk(0,1,0,0, 1,32'h08, 1,32'h00));
        tbl.push_back(mk(0,1,0,0, 1,32'h0C, 1,32'h04));
        tbl.push_back(mk(0,1,0,0, 1,32'h10, 1,32'h08));
        tbl.push_back(mk(0,0,0,0, 1,32'h14, 1,32'h0C));
        tbl.push_back(mk(0,0,0,0, 1,32'h18, 1,32'h0C));
        tbl.push_back(mk(0,0,0,0, 0,32'h00, 1,32'h0C));
        tbl.push_back(mk(0,0,0,0, 0,32'h00, 1,32'h0C));
        tbl.push_back(mk(0,0,0,0, 0,32'h00, 1,32'h0C));
        tbl.push_back(mk(0,1,0,0, 1,32'h1C, 1,32'h0C));
        tbl.push_back(mk(0,1,0,0, 1,32'h20, 1,32'h10));
        tbl.push_back(mk(0,1,0,0, 1,32'h24, 1,32'h14));
        tbl.push_back(mk(0,1,0,0, 1,32'h28, 1,32'h18));
        tbl.push_back(mk(0,1,0,0, 1,32'h2C, 1,32'h1C));
        tbl.push_back(mk(1,0,0,0, 0,32'h00, 0,0));
        tbl.push_back(mk(0,0,0,0, 0,32'h00, 0,0));
        tbl.push_back(mk(0,0,0,0, 1,32'h00, 0,0));
        tbl.push_back(mk(0,0,0,0, 1,32'h04, 0,0));
        tbl.push_back(mk(0,0,0,0, 1,32'h08, 1,32'h00));
        tbl.push_back(mk(0,0,0,0, 1,32'h0C, 1,32'h00));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0,0,0,0, 0,32'h00, 1,32'h00));
        tbl.push_back(mk(0,1,0,0, 1,32'h10, 1,32'h00));
        tbl.push_back(mk(0,1,0,0, 1,32'h14, 1,32'h04));
        tbl.push_back(mk(0,1,0,0, 1,32'h18, 1,32'h08));
        tbl.push_back(mk(0,1,0,0, 1,32'h1C, 1,32'h0C));
        tbl.push_back(mk(0,1,0,0, 1,32'h20, 1,32'h10));

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) cyc($sformatf("v%0d", i), tbl[i]);

        // Branch with three entries queued and one response in flight.
        run("br.rst", 1,0,0,0,            0,32'h0, 0,0);
        run("br.c1",  0,0,0,0,            0,32'h0, 0,0);
        run("br.c2",  0,0,0,0,            1,32'h0, 0,0);
        run("br.c3",  0,0,0,0,            1,32'h4, 0,0);
        run("br.c4",  0,0,0,0,            1,32'h8, 1,32'h0);
        run("br.c5",  0,0,0,0,            1,32'hC, 1,32'h0);
        run("br.B",   0,0,1,32'h103,      0,32'h0, 0,0);
        run("br.B1",  0,1,0,0,            1,32'h100, 0,0);
        run("br.B2",  0,1,0,0,            1,32'h104, 0,0);
        run("br.B3",  0,1,0,0,            1,32'h108, 1,32'h100);
        run("br.B4",  0,1,0,0,            1,32'h10C, 1,32'h104);

        // Back-to-back redirects: only the newer target stream appears.
        run("bb.X",   0,1,1,32'h200,      0,32'h0, 0,0);
        run("bb.X1",  0,1,1,32'h300,      0,32'h0, 0,0);
        run("bb.X2",  0,1,0,0,            1,32'h300, 0,0);
        run("bb.X3",  0,1,0,0,            1,32'h304, 0,0);
        run("bb.X4",  0,1,0,0,            1,32'h308, 1,32'h300);
        run("bb.X5",  0,1,0,0,            1,32'h30C, 1,32'h304);

        // PC wraps modulo 2^32; low target bits are ignored.
        run("wr.W",   0,1,1,32'hFFFF_FFFA, 0,32'h0, 0,0);
        run("wr.W1",  0,1,0,0,            1,32'hFFFF_FFF8, 0,0);
        run("wr.W2",  0,1,0,0,            1,32'hFFFF_FFFC, 0,0);
        run("wr.W3",  0,1,0,0,            1,32'h0000_0000, 1,32'hFFFF_FFF8);
        run("wr.W4",  0,1,0,0,            1,32'h0000_0004, 1,32'hFFFF_FFFC);
        run("wr.W5",  0,1,0,0,            1,32'h0000_0008, 1,32'h0000_0000);

        // Reset beats a same-cycle branch; a branch in the reset state is ignored.
        run("rb.R",   1,1,1,32'h500,      0,32'h0, 0,0);
        run("rb.c1",  0,1,1,32'h700,      0,32'h0, 0,0);
        run("rb.c2",  0,1,0,0,            1,32'h0, 0,0);
        run("rb.c3",  0,1,0,0,            1,32'h4, 0,0);
        run("rb.c4",  0,1,0,0,            1,32'h8, 1,32'h0);
        run("rb.c5",  0,1,0,0,            1,32'hC, 1,32'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
